rv_imm_gen_pipe: RTL and testbench
==================================

RV_IMM_GEN_PIPE -- requirements
Module: rv_imm_gen_pipe

Interface
REQ-001 SHALL have parameter: XLEN, 64, datapath width; legal values 32 or 64.
REQ-002 SHALL have port: clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: valid_i  input  1  instruction present on instr_i.
REQ-005 SHALL have port: ready_o  output  1  block can accept; registered, no combinational path from ready_i.
REQ-006 SHALL have port: instr_i  input  32  RV instruction word.
REQ-007 SHALL have port: valid_o  output  1  result present.
REQ-008 SHALL have port: ready_i  input  1  downstream accepts result.
REQ-009 SHALL have port: imm_o  output  XLEN  expanded immediate.
REQ-010 SHALL have port: fmt_o  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
REQ-011 SHALL have port: illegal_o  output  1  opcode not supported for this XLEN.

Function
REQ-012 SHALL accept on valid_i && ready_o; SHALL transfer out on valid_o && ready_i.
REQ-013 SHALL present result of an accepted instruction on the cycle after acceptance (latency 1) when the block was empty or draining.
REQ-014 SHALL decode on instr_i[6:0]: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR -> I, sign-extended instr[31:20].
REQ-015 SHALL decode OP-IMM with funct3 001/101 as SHAMT: zero-extended instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32).
REQ-016 SHALL decode 0011011 OP-IMM-32 as I (SHAMT instr[24:20] for funct3 001/101) when XLEN=64; when XLEN=32 SHALL flag illegal.
REQ-017 SHALL decode 0100011 STORE -> S, sign-extended {instr[31:25],instr[11:7]}.
REQ-018 SHALL decode 1100011 BRANCH -> B, sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-019 SHALL decode 0110111 LUI, 0010111 AUIPC -> U, {instr[31:12],12'b0} sign-extended to XLEN.
REQ-020 SHALL decode 1101111 JAL -> J, sign-extended {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
REQ-021 SHALL decode 1110011 SYSTEM -> ZIMM, zero-extended instr[19:15] when funct3[2]=1, else imm 0 with fmt ZIMM.
REQ-022 SHALL, for any other opcode, output imm 0, fmt NONE, illegal_o=1; illegal_o SHALL travel with its result.
REQ-023 SHALL buffer two entries (main, skid); states EMPTY, ONE, TWO.
REQ-024 EMPTY: accept -> ONE.
REQ-025 ONE: accept without drain -> TWO; drain without accept -> EMPTY; accept and drain same cycle -> ONE with new result.
REQ-026 TWO: ready_o=0; drain -> skid moves to main, ONE; valid_i ignored.
REQ-027 ready_o SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-028 SHALL preserve order; no result lost or duplicated under any ready_i pattern.
REQ-029 imm_o, fmt_o, illegal_o SHALL hold stable while valid_o=1 and ready_i=0.

Reset
REQ-030 On rst_i=1 at a clock edge SHALL go EMPTY: valid_o=0, ready_o=1, imm_o=0, fmt_o=0, illegal_o=0, skid cleared.
REQ-031 Reset mid-operation SHALL discard all buffered entries; valid_i during reset SHALL NOT be accepted.

Verification
REQ-032 XLEN=64, instr 0xFFF00093, ready_i=1 -> next cycle valid_o=1, imm 0xFFFFFFFFFFFFFFFF, fmt I; 0x03F09093 -> imm 63, fmt SHAMT.
REQ-033 0xFE000FE3 (beq -2) -> imm 0xFFFFFFFFFFFFFFFE, fmt B; 0x0040006F (jal 4) -> imm 4, fmt J.
REQ-034 0x800000B7 (lui) -> XLEN=64 imm 0xFFFFFFFF80000000, XLEN=32 imm 0x80000000, fmt U; XLEN=32, opcode 0011011 -> illegal_o=1, imm 0.
REQ-035 ready_i=0, three back-to-back valid_i -> two accepted, ready_o=0 after second; ready_i=1 -> results out in order, third then accepted.
REQ-036 State TWO, rst_i pulsed one cycle -> next cycle valid_o=0, ready_o=1, all outputs 0; no stale result appears afterward.

Source files
------------

// File: rtl/rv_imm_gen_pipe.sv
// RISC-V immediate generator: decodes instr_i into an XLEN immediate plus format
// tag, buffered in a two-entry main/skid pipe with a registered ready_o.
module rv_imm_gen_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ZIMM  = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } ent_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    ent_t   main_q, main_d;
    ent_t   skid_q, skid_d;
    ent_t   dec;
    logic   ready_q, ready_d;
    logic   acc, drn;

    logic [6:0] op;
    logic [2:0] f3;
    logic       is_shift;

    assign op       = instr_i[6:0];
    assign f3       = instr_i[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Signed size casts below sign-extend each raw field to XLEN.
    always_comb begin
        dec = '0;
        case (op)
            OP_LOAD, OP_JALR: begin
                dec.imm = XLEN'($signed(instr_i[31:20]));
                dec.fmt = FMT_I;
            end
            OP_IMM: begin
                if (is_shift) begin
                    dec.fmt = FMT_SHAMT;
                    if (XLEN == 64) dec.imm = XLEN'(instr_i[25:20]);
                    else            dec.imm = XLEN'(instr_i[24:20]);
                end else begin
                    dec.imm = XLEN'($signed(instr_i[31:20]));
                    dec.fmt = FMT_I;
                end
            end
            OP_IMM32: begin
                if (XLEN != 64) begin
                    dec.ill = 1'b1;
                end else if (is_shift) begin
                    dec.imm = XLEN'(instr_i[24:20]);
                    dec.fmt = FMT_SHAMT;
                end else begin
                    dec.imm = XLEN'($signed(instr_i[31:20]));
                    dec.fmt = FMT_I;
                end
            end
            OP_STORE: begin
                dec.imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
                dec.fmt = FMT_S;
            end
            OP_BRANCH: begin
                dec.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                         instr_i[11:8], 1'b0}));
                dec.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                dec.imm = XLEN'($signed({instr_i[31:12], 12'b0}));
                dec.fmt = FMT_U;
            end
            OP_JAL: begin
                dec.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                         instr_i[30:21], 1'b0}));
                dec.fmt = FMT_J;
            end
            OP_SYSTEM: begin
                dec.fmt = FMT_ZIMM;
                if (f3[2]) dec.imm = XLEN'(instr_i[19:15]);
            end
            default: begin
                dec.ill = 1'b1;
            end
        endcase
    end

    assign acc = valid_i && ready_q;
    assign drn = (state_q != S_EMPTY) && ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (acc) begin
                    main_d  = dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (acc && drn) begin
                    main_d = dec;
                end else if (acc) begin
                    skid_d  = dec;
                    state_d = S_TWO;
                end else if (drn) begin
                    main_d  = '0;
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // ready_o is low here, so nothing new can arrive while draining.
                if (drn) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = S_ONE;
                end
            end
            default: begin
                main_d  = '0;
                skid_d  = '0;
                state_d = S_EMPTY;
            end
        endcase
        ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o   = ready_q;
    assign valid_o   = (state_q != S_EMPTY);
    assign imm_o     = main_q.imm;
    assign fmt_o     = main_q.fmt;
    assign illegal_o = main_q.ill;

endmodule

// File: tb/tb_rv_imm_gen_pipe.sv
// Bench for rv_imm_gen_pipe: XLEN=64 and XLEN=32 instances share one stimulus
// stream and are checked against an arithmetic decode model and a FIFO model.
module tb_rv_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] instr = '0;

    logic        ready64, valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ready32, valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;

    int vec  = 0;
    int miss = 0;
    bit [31:0] q[$];
    bit just_rst = 1'b0;

    always #5 clk = ~clk;

    rv_imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(ready64), .instr_i(instr),
        .valid_o(valid64), .ready_i(rdy), .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64)
    );

    rv_imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(ready32), .instr_i(instr),
        .valid_o(valid32), .ready_i(rdy), .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        if (obs !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Immediate value built by weighting each field, with the sign bit as a negative weight.
    function automatic void ref_dec(input bit [31:0] ins, input int xl,
                                    output bit [63:0] imm, output bit [2:0] fmt,
                                    output bit ill);
        longint v   = 0;
        longint sgn = ins[31] ? -1 : 0;
        bit [6:0] op = ins[6:0];
        bit [2:0] f3 = ins[14:12];
        bit shift = (f3 == 3'd1) || (f3 == 3'd5);
        fmt = 3'd0;
        ill = 1'b0;
        case (op)
            7'h03, 7'h67: begin v = sgn * 2048 + longint'(ins[30:20]); fmt = 3'd1; end
            7'h13, 7'h1B: begin
                if (op == 7'h1B && xl == 32) ill = 1'b1;
                else if (shift) begin
                    fmt = 3'd6;
                    v = (op == 7'h13 && xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    v = sgn * 2048 + longint'(ins[30:20]); fmt = 3'd1;
                end
            end
            7'h23: begin v = sgn * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]); fmt = 3'd2; end
            7'h63: begin
                v = sgn * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                    + longint'(ins[11:8]) * 2;
                fmt = 3'd3;
            end
            7'h37, 7'h17: begin v = sgn * 64'sd2147483648 + longint'(ins[30:12]) * 4096; fmt = 3'd4; end
            7'h6F: begin
                v = sgn * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                    + longint'(ins[30:21]) * 2;
                fmt = 3'd5;
            end
            7'h73: begin fmt = 3'd7; v = f3[2] ? longint'(ins[19:15]) : 0; end
            default: ill = 1'b1;
        endcase
        imm = (xl == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
    endfunction

    task automatic model_check();
        bit [63:0] ei;
        bit [2:0]  ef;
        bit        el;
        chk("ready64", 64'(ready64), 64'(q.size() < 2));
        chk("valid64", 64'(valid64), 64'(q.size() > 0));
        chk("ready32", 64'(ready32), 64'(q.size() < 2));
        chk("valid32", 64'(valid32), 64'(q.size() > 0));
        if (q.size() > 0) begin
            ref_dec(q[0], 64, ei, ef, el);
            chk("imm64", imm64, ei);
            chk("fmt64", 64'(fmt64), 64'(ef));
            chk("ill64", 64'(ill64), 64'(el));
            ref_dec(q[0], 32, ei, ef, el);
            chk("imm32", {32'b0, imm32}, ei);
            chk("fmt32", 64'(fmt32), 64'(ef));
            chk("ill32", 64'(ill32), 64'(el));
        end else if (just_rst) begin
            chk("rst_imm64", imm64, 64'd0);
            chk("rst_fmt64", 64'(fmt64), 64'd0);
            chk("rst_ill64", 64'(ill64), 64'd0);
            chk("rst_imm32", {32'b0, imm32}, 64'd0);
            chk("rst_fmt32", 64'(fmt32), 64'd0);
            chk("rst_ill32", 64'(ill32), 64'd0);
        end
    endtask

    // Drive one cycle of inputs, update the FIFO model at the edge, check at the falling edge.
    task automatic cycle(input bit v, input bit [31:0] ins, input bit r, input bit rs);
        bit acc, drn;
        vld = v; instr = ins; rdy = r; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            just_rst = 1'b1;
        end else begin
            just_rst = 1'b0;
            acc = v && (q.size() < 2);
            drn = (q.size() > 0) && r;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ins);
        end
        @(negedge clk);
        model_check();
    endtask

    bit [6:0] ops[12];

    initial begin
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F};

        cycle(0, 32'h0, 0, 1);
        cycle(0, 32'h0, 0, 1);
        chk("rst_valid", 64'(valid64), 64'd0);
        chk("rst_ready", 64'(ready64), 64'd1);

        cycle(1, 32'hFFF00093, 1, 0);
        chk("addi_m1_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_m1_fmt", 64'(fmt64), 64'd1);
        cycle(1, 32'h03F09093, 1, 0);
        chk("slli63_imm", imm64, 64'd63);
        chk("slli63_fmt", 64'(fmt64), 64'd6);
        cycle(1, 32'hFE000FE3, 1, 0);
        chk("beq_m2_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("beq_m2_fmt", 64'(fmt64), 64'd3);
        cycle(1, 32'h0040006F, 1, 0);
        chk("jal4_imm", imm64, 64'd4);
        chk("jal4_fmt", 64'(fmt64), 64'd5);
        cycle(1, 32'h800000B7, 1, 0);
        chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui_imm32", {32'b0, imm32}, 64'h0000_0000_8000_0000);
        chk("lui_fmt", 64'(fmt32), 64'd4);
        cycle(1, 32'h0010009B, 1, 0);
        chk("addiw_ill32", 64'(ill32), 64'd1);
        chk("addiw_imm32", {32'b0, imm32}, 64'd0);
        chk("addiw_ill64", 64'(ill64), 64'd0);
        cycle(0, 32'h0, 1, 0);

        // Back-pressure: third instruction is refused until a slot frees up.
        cycle(1, 32'h00100093, 0, 0);
        cycle(1, 32'h00200093, 0, 0);
        chk("full_ready", 64'(ready64), 64'd0);
        cycle(1, 32'h00300093, 0, 0);
        chk("hold_imm", imm64, 64'd1);
        cycle(1, 32'h00300093, 1, 0);
        chk("order2_imm", imm64, 64'd2);
        cycle(1, 32'h00300093, 1, 0);
        chk("order3_imm", imm64, 64'd3);
        cycle(0, 32'h0, 1, 0);
        chk("drained", 64'(valid64), 64'd0);

        // Reset while full must drop both entries and ignore valid_i.
        cycle(1, 32'h00500093, 0, 0);
        cycle(1, 32'h00600093, 0, 0);
        cycle(1, 32'h00700093, 0, 1);
        chk("rst_full_valid", 64'(valid64), 64'd0);
        chk("rst_full_ready", 64'(ready64), 64'd1);
        chk("rst_full_imm", imm64, 64'd0);
        cycle(0, 32'h0, 1, 0);
        chk("no_stale", 64'(valid64), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            bit [31:0] w;
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 11)];
            cycle(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
